// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Read-mode strings, default thresholds and pointer/depth sizing.
package sync_fifo_pkg;

    localparam string FIFO_MODE_FWFT = "TRUE";
    localparam string FIFO_MODE_REG  = "FALSE";

    localparam int DEFAULT_ADDRSIZE      = 4;
    localparam int DEFAULT_AEMPTY_THRESH = 1;

    // One extra pointer bit distinguishes full from empty when addresses match.
    function automatic int ptr_bits(input int addrsize);
        return addrsize + 1;
    endfunction

    function automatic int fifo_depth(input int addrsize);
        return 1 << addrsize;
    endfunction

    function automatic int default_afull_thresh(input int addrsize);
        return (1 << addrsize) - 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one write port and a read port that is either
// combinational (fall-through) or registered with a read enable.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = DEFAULT_ADDRSIZE,
    parameter bit FWFT     = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we_i,
    input  logic [ADDRSIZE-1:0] waddr_i,
    input  logic [DATASIZE-1:0] wdata_i,
    input  logic                re_i,
    input  logic [ADDRSIZE-1:0] raddr_i,
    output logic [DATASIZE-1:0] rdata_o
);

    localparam int DEPTH = fifo_depth(ADDRSIZE);

    // Contents are deliberately not reset; only pointers define validity.
    logic [DATASIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            logic unused_regport;
            assign unused_regport = rst_n ^ re_i;
            assign rdata_o        = mem_q[raddr_i];
        end else begin : g_reg
            logic [DATASIZE-1:0] rdata_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (re_i) begin
                    rdata_q <= mem_q[raddr_i];
                end
            end
            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, thresholds, flush and selectable read mode.
// Define SYNC_FIFO_ERR_EN to build the sticky overflow/underflow registers.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int    DATASIZE      = 8,
    parameter int    ADDRSIZE      = DEFAULT_ADDRSIZE,
    parameter string FALLTHROUGH   = FIFO_MODE_FWFT,
    parameter int    AFULL_THRESH  = default_afull_thresh(ADDRSIZE),
    parameter int    AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                wr_en,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rd_en,
    output logic [DATASIZE-1:0] rdata,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int PW = ptr_bits(ADDRSIZE);
    localparam bit IS_FWFT = (FALLTHROUGH == FIFO_MODE_FWFT);
    localparam logic [PW-1:0] PTR_ONE  = {{ADDRSIZE{1'b0}}, 1'b1};
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THRESH);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          wrAccept;
    logic          rdAccept;

    assign full  = (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]) &&
                   (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]);
    assign empty = (wptr_q == rptr_q);

    assign wrAccept = wr_en && !full;
    assign rdAccept = rd_en && !empty;

    assign count        = count_q;
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);

    // Flush wins over any write or read presented in the same cycle.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wrAccept) wptr_d = wptr_q + PTR_ONE;
            if (rdAccept) rptr_d = rptr_q + PTR_ONE;
            if (wrAccept && !rdAccept) begin
                count_d = count_q + PTR_ONE;
            end else if (rdAccept && !wrAccept) begin
                count_d = count_q - PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    sync_fifo_mem #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE),
        .FWFT     (IS_FWFT)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (wrAccept && !flush),
        .waddr_i  (wptr_q[ADDRSIZE-1:0]),
        .wdata_i  (wdata),
        .re_i     (rdAccept && !flush),
        .raddr_i  (rptr_q[ADDRSIZE-1:0]),
        .rdata_o  (rdata)
    );

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full)  overflow_q  <= 1'b1;
            if (rd_en && empty) underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
